// File: rtl/bcd_display_scanner_pkg.sv
// Shared 7-segment definitions: active-high glyphs and segment bit positions.
// Display blocks apply output polarity themselves.
package bcd_display_scanner_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  // Segment bit order within a pattern: seg[0]=a ... seg[6]=g
  localparam int unsigned SEG_A_BIT = 0;
  localparam int unsigned SEG_B_BIT = 1;
  localparam int unsigned SEG_C_BIT = 2;
  localparam int unsigned SEG_D_BIT = 3;
  localparam int unsigned SEG_E_BIT = 4;
  localparam int unsigned SEG_F_BIT = 5;
  localparam int unsigned SEG_G_BIT = 6;

  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Digit/control inputs and multiplexed display outputs of the scanner.
interface bcd_display_scanner_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   dp_in;
  logic                blank_lz;
  logic                en;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output bcd, dp_in, blank_lz, en,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  bcd, dp_in, blank_lz, en,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/bcd_display_scanner_bcd_to_7seg.sv
// Combinational BCD to active-high 7-segment decoder; codes A-F show a dash.
module bcd_to_7seg
  import bcd_display_scanner_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner: per-frame snapshot of BCD digits,
// one guard cycle per slot, leading-zero blanking and a frame-done strobe.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_display_scanner_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BUS_W = BCD_W * DIGITS;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [SEG_W-1:0]  SEG_INV  = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_INV   = {DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BUS_W-1:0]  shadow_bcd_q, shadow_bcd_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q, frame_done_d;

  logic [DIGITS-1:0] zero_above;
  logic              zero_run;
  logic [BCD_W-1:0]  sel_digit;
  logic              sel_dp;
  logic              sel_blank;
  logic [DIGITS-1:0] sel_an;
  logic [SEG_W-1:0]  seg_dec_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= SEG_OFF ^ SEG_INV;
      dp_q         <= SEG_ACTIVE_LOW;
      an_q         <= AN_INV;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Slot prescaler and digit index; the snapshot is taken on the frame wrap
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    frame_done_d = 1'b0;
    if (bus.en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d        = '0;
          shadow_bcd_d = bus.bcd;
          shadow_dp_d  = bus.dp_in;
          frame_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // zero_above[i]: shadow digits i..DIGITS-1 are all zero (post-edge view)
  always_comb begin
    zero_above = '0;
    zero_run   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run      = zero_run && (shadow_bcd_d[BCD_W*i +: BCD_W] == 4'd0);
      zero_above[i] = zero_run;
    end
  end

  always_comb begin
    sel_digit = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_an    = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_d == IDX_W'(i)) begin
        sel_digit = shadow_bcd_d[BCD_W*i +: BCD_W];
        sel_dp    = shadow_dp_d[i];
        sel_blank = bus.blank_lz && (i != 0) && zero_above[i];
        sel_an[i] = 1'b1;
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd_i (sel_digit),
    .seg_o (seg_dec_c)
  );

  // Outputs follow the post-edge slot; guard cycle and blanked slots stay dark
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    an_d  = '0;
    if (bus.en && (cnt_d != '0) && !sel_blank) begin
      seg_d = seg_dec_c;
      dp_d  = sel_dp;
      an_d  = sel_an;
    end
    seg_d = seg_d ^ SEG_INV;
    dp_d  = dp_d ^ SEG_ACTIVE_LOW;
    an_d  = an_d ^ AN_INV;
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with DIGITS=4, PRESCALE=4, active-low outputs.
module tb_bcd_display_scanner;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  bcd_display_scanner_if #(.DIGITS(4)) bus ();

  bcd_display_scanner #(
    .DIGITS         (4),
    .PRESCALE       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      bcd;
    logic [3:0]       dp_in;
    logic             lz;
    logic [3:0][3:0]  an;
    logic [3:0][6:0]  seg;
    logic [3:0]       dp;
  } vec_t;

  vec_t vec [8];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge sample where frame_done is high
  task automatic wait_fd();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("frame_done_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;

    vec[0] = '{16'h1234, 4'h0, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
    vec[1] = '{16'h1234, 4'h0, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
    vec[2] = '{16'h0070, 4'h0, 1'b1, {4'hF, 4'hF, 4'hD, 4'hE}, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF};
    vec[3] = '{16'h0000, 4'h0, 1'b1, {4'hF, 4'hF, 4'hF, 4'hE}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
    vec[4] = '{16'h00C0, 4'h2, 1'b1, {4'hF, 4'hF, 4'hD, 4'hE}, {7'h7F, 7'h7F, 7'h3F, 7'h40}, 4'hD};
    vec[5] = '{16'h0070, 4'h0, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h40, 7'h40, 7'h78, 7'h40}, 4'hF};
    vec[6] = '{16'h5678, 4'hA, 1'b1, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h12, 7'h02, 7'h78, 7'h00}, 4'h5};
    vec[7] = '{16'h0F05, 4'hF, 1'b1, {4'hF, 4'hB, 4'hD, 4'hE}, {7'h7F, 7'h3F, 7'h40, 7'h12}, 4'h8};

    // Reset state; live bcd must not show before the first frame wrap
    rst_n        = 1'b0;
    bus.en       = 1'b1;
    bus.bcd      = 16'h1234;
    bus.dp_in    = 4'h0;
    bus.blank_lz = 1'b0;
    step(3);
    check("rst_an",  16'(bus.an), 16'hF);
    check("rst_seg", 16'(bus.seg), 16'h7F);
    check("rst_dp",  16'(bus.dp), 16'h1);
    check("rst_fd",  16'(bus.frame_done), 16'h0);
    rst_n = 1'b1;
    step(1);
    check("post_rst_an",  16'(bus.an), 16'hE);
    check("post_rst_seg", 16'(bus.seg), 16'h40);
    step(1);
    check("post_rst_seg2", 16'(bus.seg), 16'h40);

    // Table-driven frames: sample k=0 is the frame_done guard cycle
    for (int v = 0; v < 8; v++) begin
      bus.bcd      = vec[v].bcd;
      bus.dp_in    = vec[v].dp_in;
      bus.blank_lz = vec[v].lz;
      wait_fd();
      for (int k = 0; k < 16; k++) begin
        if (k > 0) begin
          step(1);
          check("fd_low", 16'(bus.frame_done), 16'h0);
        end
        if (k % 4 == 0) begin
          check("guard_an",  16'(bus.an), 16'hF);
          check("guard_seg", 16'(bus.seg), 16'h7F);
          check("guard_dp",  16'(bus.dp), 16'h1);
        end else begin
          check("slot_an",  16'(bus.an), 16'(vec[v].an[k/4]));
          check("slot_seg", 16'(bus.seg), 16'(vec[v].seg[k/4]));
          check("slot_dp",  16'(bus.dp), 16'(vec[v].dp[k/4]));
        end
      end
      step(1);
      check("fd_period", 16'(bus.frame_done), 16'h1);
    end

    // Snapshot coherence: mid-frame bcd change waits for the next frame
    bus.bcd      = 16'h1234;
    bus.dp_in    = 4'h0;
    bus.blank_lz = 1'b0;
    wait_fd();
    step(5);
    check("coh_d1_an",  16'(bus.an), 16'hD);
    check("coh_d1_seg", 16'(bus.seg), 16'h30);
    bus.bcd = 16'h9999;
    step(4);
    check("coh_d2_seg", 16'(bus.seg), 16'h24);
    step(4);
    check("coh_d3_seg", 16'(bus.seg), 16'h79);
    step(3);
    check("coh_fd", 16'(bus.frame_done), 16'h1);
    step(1);
    check("coh_new_an",  16'(bus.an), 16'hE);
    check("coh_new_seg", 16'(bus.seg), 16'h10);
    step(1);
    check("coh_new_seg2", 16'(bus.seg), 16'h10);

    // Enable freeze at idx=2, cnt=2
    bus.bcd = 16'h1234;
    wait_fd();
    step(10);
    check("en_pre_an",  16'(bus.an), 16'hB);
    check("en_pre_seg", 16'(bus.seg), 16'h24);
    bus.en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step(1);
      check("en_off_an", 16'(bus.an), 16'hF);
      check("en_off_fd", 16'(bus.frame_done), 16'h0);
    end
    bus.en = 1'b1;
    step(1);
    check("en_resume_an", 16'(bus.an), 16'hB);
    step(1);
    check("en_guard_an", 16'(bus.an), 16'hF);
    step(1);
    check("en_d3_an",  16'(bus.an), 16'h7);
    check("en_d3_seg", 16'(bus.seg), 16'h79);
    step(1);
    check("en_fd_low1", 16'(bus.frame_done), 16'h0);
    step(1);
    check("en_fd_low2", 16'(bus.frame_done), 16'h0);
    step(1);
    check("en_fd", 16'(bus.frame_done), 16'h1);
    step(1);
    check("pre_rst_an",  16'(bus.an), 16'hE);
    check("pre_rst_seg", 16'(bus.seg), 16'h19);

    // Asynchronous reset mid-slot
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an",  16'(bus.an), 16'hF);
    check("async_rst_seg", 16'(bus.seg), 16'h7F);
    check("async_rst_dp",  16'(bus.dp), 16'h1);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("rel_an",  16'(bus.an), 16'hE);
    check("rel_seg", 16'(bus.seg), 16'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Consumer end of the BCD counter chain. Takes DIGITS packed BCD digits from a cascade of decade counters and drives a time-multiplexed common-anode/common-cathode 7-segment display.
- Latches a coherent snapshot once per frame. Scans one digit per PRESCALE clocks, with a one-cycle ghosting guard.
- Supports leading-zero blanking, per-digit decimal points and a frame-done strobe.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- PRESCALE, 50000, clk cycles per digit slot (≥2).
- SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs active-low.
- AN_ACTIVE_LOW, 1, 1 = anode enables active-low.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- bcd  in  4*DIGITS  packed digits, bcd[3:0] = least significant digit.
- dp_in  in  DIGITS  decimal point per digit, bit i = digit i.
- blank_lz  in  1  1 = blank leading zeros.
- en  in  1  1 = scanning enabled.
- seg  out  7  segments, seg[0]=a … seg[6]=g.
- dp  out  1  decimal point of the active digit.
- an  out  DIGITS  one-hot digit enable.
- frame_done  out  1  one-cycle pulse per completed frame.

Behaviour:
- Reset (async assert, sync release):
  - Counters: cnt=0, idx=0.
  - Shadow registers cleared.
  - All outputs inactive: an all off, seg all off, dp off, frame_done=0.
- Prescaler cnt counts 0..PRESCALE-1 while en=1. At PRESCALE-1 it wraps to 0 and idx advances idx+1, with DIGITS-1 → 0 wrap.
- Snapshot:
  - On the edge where idx wraps DIGITS-1 → 0, shadow_bcd <= bcd and shadow_dp <= dp_in.
  - frame_done=1 for exactly the following cycle.
  - Input changes mid-frame are never visible until the next frame.
- All outputs are registered, evaluated on the post-edge cnt/idx:
  - cnt==0 (guard cycle): an all off, seg/dp off.
  - cnt≥1: an = onehot(idx); seg = decode(shadow_bcd digit idx); dp = shadow_dp[idx].
- Decode (active-high form): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Invalid codes A–F show dash 40.
  - Invert seg/dp when SEG_ACTIVE_LOW; invert an when AN_ACTIVE_LOW.
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked if it and all higher shadow digits equal 0 and i≠0. Digit 0 is never blanked.
  - Invalid codes count as nonzero.
  - A blanked digit drives an off for its whole slot, dp included.
  - blank_lz is sampled live, not shadowed.
- en=0:
  - cnt and idx hold; an/seg/dp go inactive on the next edge; frame_done=0; no snapshot.
  - On en=1, the slot resumes at the held cnt/idx; an is driven from the next edge if cnt≥1.
- Reset mid-frame returns immediately to the reset state. The first frame after release shows zeros (shadow cleared) until the first wrap.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - The 7-segment pattern constants SEG_0..SEG_9 and SEG_DASH.
  - SEG_OFF.
  - The segment bit-order constants.
  These constants are reused by later display blocks.
- Natural sub-module: bcd_to_7seg, a purely combinational 4-bit → 7-bit decoder with dash for invalid codes. Polarity is handled in the scanner.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=4, both polarities active-low.
- Reset: hold rst_n=0 → an=4'b1111, seg=7'h7F, dp=1, frame_done=0. Release → first slot idx=0 shows 0 (seg=7'h40).
- bcd=16'h1234, dp_in=0, blank_lz=0, run 2 frames (second frame digits must match the first):
  - Digit slots:
    - Digit 0: an=4'b1110, seg=7'h19.
    - Digit 1: an=1101, seg=7'h30.
    - Digit 2: an=1011, seg=7'h24.
    - Digit 3: an=0111, seg=7'h79.
  - Guard cycles: each guard cycle has an=1111.
  - frame_done: pulses every 16 cycles.
- Leading-zero blanking with blank_lz=1:
  - bcd=16'h0070: digits 3,2 keep an=1111 for their full slots; digit 1 seg=7'h78; digit 0 seg=7'h40.
  - bcd=16'h0000: only digit 0 lit, seg=7'h40.
- Snapshot coherence: load 16'h1234, then change bcd to 16'h9999 while idx=1 → remainder of frame still shows 2,1. 9s appear (seg=7'h10) only after the next frame_done.
- Invalid code and dp: bcd=16'h00C0 with dp_in=4'b0010, blank_lz=1 → digit 1 seg=7'h3F, dp=0 (lit). Digits 2,3 blanked.
- Enable and reset:
  - Deassert en at idx=2, cnt=2 for 10 cycles → an=1111, cnt/idx frozen, no frame_done. Reassert → idx=2 slot completes (1 more cycle) before idx=3.
  - Pulse rst_n low mid-slot → outputs inactive asynchronously, idx=0 after release.
